// File: rtl/cmd_cfg_mc_if.sv
// cmd_cfg_mc_if: command/response handshake between the UART/BLE link wrapper
// (master) and the command interpreter (slave).
interface cmd_cfg_mc_if #(
  parameter int DATA_W = 16
);
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic [7:0]        resp;
  logic              send_resp;

  modport master (
    output cmd, data, cmd_rdy,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd, data, cmd_rdy,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: multi-channel command interpreter for the quad flight controller.
// Holds NUM_SP signed setpoints and a thrust register, sequences battery reads
// and the motor-ramp / inertial-calibration flow, answers every command with a
// response byte (0xA5 ack, 0xEE nack, or the battery reading).
// Optional: define CMD_WDOG_EN to build the link-loss watchdog.
//
// state | meaning
// IDLE  | waiting for cmd_rdy; decodes and applies register writes
// BATT  | ADC conversion in flight, waiting for cnv_cmplt
// ACK   | one-cycle 0xA5 response and command consume
// NACK  | one-cycle 0xEE response for an illegal opcode
// RAMP  | motors spinning up for 2^RAMP_W cycles
// CAL   | inertial calibration running, waiting for cal_done
module cmd_cfg_mc #(
  parameter int NUM_SP  = 3,
  parameter int SP_W    = 16,
  parameter int THRST_W = 9,
  parameter int DATA_W  = 16,
  parameter int RAMP_W  = 9,
  parameter int WDOG_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  cmd_cfg_mc_if.slave              link,
  input  logic [7:0]               batt,
  input  logic                     cnv_cmplt,
  input  logic                     cal_done,
  output logic [NUM_SP*SP_W-1:0]   sp,
  output logic [THRST_W-1:0]       thrst,
  output logic                     strt_cnv,
  output logic                     strt_cal,
  output logic                     inertial_cal,
  output logic                     motors_off,
  output logic                     wdog_trip
);

  localparam logic [7:0] OP_REQ_BATT  = 8'h01;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;
  localparam logic [7:0] RESP_ACK     = 8'hA5;
  localparam logic [7:0] RESP_NACK    = 8'hEE;
  localparam logic [4:0] NUM_SP_L     = 5'(NUM_SP);

  typedef enum logic [2:0] {S_IDLE, S_BATT, S_ACK, S_NACK, S_RAMP, S_CAL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_w;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic                ramp_tc;
  logic                accept;
  logic                op_sp;
  logic                op_legal;
  logic                zero_evt;
  logic                wdog_fire;

  assign data_w   = link.data;
  // rst gates accept so the IDLE-cycle strobes stay quiet while reset is held
  assign accept   = (state_q == S_IDLE) && link.cmd_rdy && !rst;
  assign op_sp    = (link.cmd[7:4] == 4'h1) && ({1'b0, link.cmd[3:0]} < NUM_SP_L);
  assign op_legal = op_sp || (link.cmd == OP_REQ_BATT) || (link.cmd == OP_SET_THRST) ||
                    (link.cmd == OP_CALIBRATE) || (link.cmd == OP_EMER_LAND) ||
                    (link.cmd == OP_MTRS_OFF);
  assign ramp_tc  = (ramp_cnt == '0);
  assign zero_evt = (accept && link.cmd == OP_EMER_LAND) || wdog_fire;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op_legal)                     state_d = S_NACK;
          else if (link.cmd == OP_REQ_BATT)  state_d = S_BATT;
          else if (link.cmd == OP_CALIBRATE) state_d = S_RAMP;
          else                               state_d = S_ACK;
        end
      end
      S_BATT:        if (cnv_cmplt) state_d = S_IDLE;
      S_ACK, S_NACK: state_d = S_IDLE;
      S_RAMP:        if (ramp_tc) state_d = S_CAL;
      S_CAL:         if (cal_done) state_d = S_ACK;
      default:       state_d = S_IDLE;
    endcase
  end

  // strobes and response byte
  always_comb begin
    link.resp        = RESP_ACK;
    link.send_resp   = 1'b0;
    link.clr_cmd_rdy = 1'b0;
    strt_cnv         = 1'b0;
    strt_cal         = 1'b0;
    inertial_cal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        strt_cnv         = accept && (link.cmd == OP_REQ_BATT);
        // calibration consumes the command up front; the final ACK consumes again
        link.clr_cmd_rdy = accept && (link.cmd == OP_CALIBRATE);
      end
      S_BATT: begin
        if (cnv_cmplt) begin
          link.resp        = batt;
          link.send_resp   = 1'b1;
          link.clr_cmd_rdy = 1'b1;
        end
      end
      S_ACK: begin
        link.send_resp   = 1'b1;
        link.clr_cmd_rdy = 1'b1;
      end
      S_NACK: begin
        link.resp        = RESP_NACK;
        link.send_resp   = 1'b1;
        link.clr_cmd_rdy = 1'b1;
      end
      S_RAMP:  strt_cal     = ramp_tc;
      S_CAL:   inertial_cal = 1'b1;
      default: ;
    endcase
  end

  // ramp timer: reloads outside RAMP, terminal count after 2^RAMP_W RAMP cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ramp_cnt <= '1;
    else if (state_q != S_RAMP) ramp_cnt <= '1;
    else                        ramp_cnt <= ramp_cnt - RAMP_W'(1);
  end

  // setpoint and thrust registers; zeroing beats a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      thrst <= '0;
    end else if (zero_evt) begin
      sp    <= '0;
      thrst <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_SP; k++) begin
        if (op_sp && link.cmd[3:0] == 4'(k)) sp[k*SP_W +: SP_W] <= data_w[SP_W-1:0];
      end
      if (link.cmd == OP_SET_THRST) thrst <= data_w[THRST_W-1:0];
    end
  end

  // motor enable: MTRS_OFF disables, CALIBRATE enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       motors_off <= 1'b1;
    else if (accept && link.cmd == OP_MTRS_OFF)    motors_off <= 1'b1;
    else if (accept && link.cmd == OP_CALIBRATE)   motors_off <= 1'b0;
  end

`ifdef CMD_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_cnt_en;

  assign wdog_cnt_en = !motors_off && (state_q == S_IDLE) && !link.cmd_rdy;
  // trips on the (2^WDOG_W - 1)th consecutive silent idle cycle with motors on
  assign wdog_fire   = wdog_cnt_en && (wdog_cnt == WDOG_W'(1));

  // link-loss down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 wdog_cnt <= '1;
    else if (wdog_fire || accept || motors_off) wdog_cnt <= '1;
    else if (wdog_cnt_en)                    wdog_cnt <= wdog_cnt - WDOG_W'(1);
  end

  // sticky trip flag, cleared by the next legal command
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        wdog_trip <= 1'b0;
    else if (wdog_fire)             wdog_trip <= 1'b1;
    else if (accept && op_legal)    wdog_trip <= 1'b0;
  end
`else
  assign wdog_fire = 1'b0;
  // no watchdog: flag tied low (WDOG_W is always at least 1)
  assign wdog_trip = (WDOG_W < 1);
`endif

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// tb_cmd_cfg_mc: self-checking bench for cmd_cfg_mc with a command-level model.
`timescale 1ns/1ps
module tb_cmd_cfg_mc;
  localparam int NUM_SP  = 3;
  localparam int SP_W    = 16;
  localparam int THRST_W = 9;
  localparam int DATA_W  = 16;
  localparam int RAMP_W  = 9;
  localparam int WDOG_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             batt;
  logic                   cnv_cmplt;
  logic                   cal_done;
  logic [NUM_SP*SP_W-1:0] sp;
  logic [THRST_W-1:0]     thrst;
  logic                   strt_cnv, strt_cal, inertial_cal, motors_off, wdog_trip;

  cmd_cfg_mc_if #(.DATA_W(DATA_W)) link ();

  cmd_cfg_mc #(
    .NUM_SP(NUM_SP), .SP_W(SP_W), .THRST_W(THRST_W),
    .DATA_W(DATA_W), .RAMP_W(RAMP_W), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .rst(rst), .link(link), .batt(batt), .cnv_cmplt(cnv_cmplt),
    .cal_done(cal_done), .sp(sp), .thrst(thrst), .strt_cnv(strt_cnv),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal), .motors_off(motors_off),
    .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // command-level reference model
  logic [SP_W-1:0]    sp_m [NUM_SP];
  logic [THRST_W-1:0] thrst_m;
  logic               motors_m;
  logic               trip_m;

  function automatic logic legal(input logic [7:0] op);
    return (op == 8'h01) || (op == 8'h05) || (op == 8'h06) || (op == 8'h07) ||
           (op == 8'h08) || (int'(op) >= 16 && int'(op) < 16 + NUM_SP);
  endfunction

  function automatic logic [NUM_SP*SP_W-1:0] pack_sp();
    logic [NUM_SP*SP_W-1:0] r;
    for (int k = 0; k < NUM_SP; k++) r[k*SP_W +: SP_W] = sp_m[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_SP; k++) sp_m[k] = '0;
    thrst_m  = '0;
    motors_m = 1'b1;
    trip_m   = 1'b0;
  endtask

  task automatic model_apply(input logic [7:0] op, input logic [DATA_W-1:0] dat);
    int ch;
    ch = int'(op) - 16;
    if (legal(op)) trip_m = 1'b0;
    if (ch >= 0 && ch < NUM_SP) sp_m[ch] = dat[SP_W-1:0];
    if (op == 8'h05) thrst_m = dat[THRST_W-1:0];
    if (op == 8'h07) begin
      for (int k = 0; k < NUM_SP; k++) sp_m[k] = '0;
      thrst_m = '0;
    end
    if (op == 8'h08) motors_m = 1'b1;
    if (op == 8'h06) motors_m = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] op, input logic [DATA_W-1:0] dat);
    step();
    link.cmd     = op;
    link.data    = dat;
    link.cmd_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({sp, thrst, motors_off, wdog_trip, link.resp, link.send_resp, link.clr_cmd_rdy,
         strt_cnv, strt_cal, inertial_cal} !== {{(NUM_SP*SP_W+THRST_W){1'b0}}, 2'b10, 8'hA5, 5'b0})
      begin
        errors++;
        $display("FAIL reset_values: sp=%h thrst=%h moff=%b trip=%b resp=%h strobes=%b%b%b%b%b",
                 sp, thrst, motors_off, wdog_trip, link.resp, link.send_resp,
                 link.clr_cmd_rdy, strt_cnv, strt_cal, inertial_cal);
      end
    step();
    rst = 1'b0;
    model_reset();
  endtask

  // single-response command: ACK/NACK lands one cycle after acceptance
  task automatic run_cmd(input logic [7:0] op, input logic [DATA_W-1:0] dat);
    logic [7:0] exp_resp;
    exp_resp = legal(op) ? 8'hA5 : 8'hEE;
    present(op, dat);
    @(negedge clk);
    checks++;
    if (link.send_resp !== 1'b0 || link.clr_cmd_rdy !== 1'b0 || strt_cnv !== 1'b0) begin
      errors++;
      $display("FAIL cmd_cycle_quiet op=%h: send=%b clr=%b cnv=%b want 0 0 0",
               op, link.send_resp, link.clr_cmd_rdy, strt_cnv);
    end
    model_apply(op, dat);
    step();
    @(negedge clk);
    checks++;
    if (link.send_resp !== 1'b1 || link.clr_cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL resp_strobes op=%h: send=%b clr=%b want 1 1", op, link.send_resp, link.clr_cmd_rdy);
    end
    checks++;
    if (link.resp !== exp_resp) begin
      errors++;
      $display("FAIL resp_byte op=%h: got %h want %h", op, link.resp, exp_resp);
    end
    checks++;
    if (sp !== pack_sp() || thrst !== thrst_m || motors_off !== motors_m || wdog_trip !== trip_m) begin
      errors++;
      $display("FAIL regs op=%h: sp=%h thrst=%h moff=%b trip=%b want sp=%h thrst=%h moff=%b trip=%b",
               op, sp, thrst, motors_off, wdog_trip, pack_sp(), thrst_m, motors_m, trip_m);
    end
    step();
    link.cmd_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (link.send_resp !== 1'b0) begin
      errors++;
      $display("FAIL resp_one_cycle op=%h: send=%b want 0", op, link.send_resp);
    end
  endtask

  task automatic test_set_sp();
    run_cmd(8'h11, 16'h8001);
    checks++;
    if (sp !== {16'h0000, 16'h8001, 16'h0000}) begin
      errors++;
      $display("FAIL set_sp1: sp=%h want 000080010000", sp);
    end
  endtask

  task automatic test_thrst_emer();
    run_cmd(8'h05, 16'hFFFF);
    checks++;
    if (thrst !== 9'h1FF) begin
      errors++;
      $display("FAIL thrst_trunc: got %h want 1ff", thrst);
    end
    run_cmd(8'h07, 16'(32'($urandom)));
    checks++;
    if (sp !== '0 || thrst !== '0) begin
      errors++;
      $display("FAIL emer_land: sp=%h thrst=%h want 0 0", sp, thrst);
    end
  endtask

  task automatic test_batt(input int dly, input logic [7:0] b);
    int pulses;
    int noise;
    pulses = 0;
    noise  = 0;
    present(8'h01, 16'h0);
    @(negedge clk);
    if (strt_cnv === 1'b1) pulses++;
    if (link.send_resp !== 1'b0) noise++;
    for (int d = 1; d < dly; d++) begin
      step();
      @(negedge clk);
      if (strt_cnv === 1'b1) pulses++;
      if (link.send_resp !== 1'b0 || link.clr_cmd_rdy !== 1'b0) noise++;
    end
    step();
    cnv_cmplt = 1'b1;
    batt      = b;
    @(negedge clk);
    checks++;
    if (link.send_resp !== 1'b1 || link.clr_cmd_rdy !== 1'b1 || link.resp !== b) begin
      errors++;
      $display("FAIL batt_resp: send=%b clr=%b resp=%h want 1 1 %h",
               link.send_resp, link.clr_cmd_rdy, link.resp, b);
    end
    step();
    cnv_cmplt    = 1'b0;
    link.cmd_rdy = 1'b0;
    @(negedge clk);
    if (strt_cnv === 1'b1) pulses++;
    if (link.send_resp !== 1'b0) noise++;
    checks++;
    if (pulses != 1 || noise != 0) begin
      errors++;
      $display("FAIL batt_pulses: strt_cnv pulses=%0d stray=%0d want 1 0", pulses, noise);
    end
  endtask

  task automatic test_nack();
    run_cmd(8'h10, 16'h4321);
    run_cmd(8'h13, 16'h1234);
    run_cmd(8'h00, 16'h5678);
  endtask

  task automatic test_calibrate();
    int  ramp_len;
    int  bad;
    int  cal_bad;
    logic found;
    present(8'h06, 16'h0);
    @(negedge clk);
    checks++;
    if (link.clr_cmd_rdy !== 1'b1 || link.send_resp !== 1'b0) begin
      errors++;
      $display("FAIL cal_clr_now: clr=%b send=%b want 1 0", link.clr_cmd_rdy, link.send_resp);
    end
    model_apply(8'h06, 16'h0);
    found    = 1'b0;
    ramp_len = 0;
    bad      = 0;
    for (int i = 1; i <= 1000 && !found; i++) begin
      step();
      if (i == 1) link.cmd_rdy = 1'b0;
      @(negedge clk);
      if (motors_off !== 1'b0 || inertial_cal !== 1'b0 || link.send_resp !== 1'b0) bad++;
      if (strt_cal === 1'b1) begin
        found    = 1'b1;
        ramp_len = i;
      end
    end
    checks++;
    if (!found || ramp_len != (1 << RAMP_W)) begin
      errors++;
      $display("FAIL ramp_len: strt_cal after %0d cycles (found=%b) want %0d", ramp_len, found, 1 << RAMP_W);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ramp_outputs: %0d bad cycles want 0", bad);
    end
    cal_bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (inertial_cal !== 1'b1 || strt_cal !== 1'b0 || link.send_resp !== 1'b0) cal_bad++;
    end
    step();
    cal_done = 1'b1;
    @(negedge clk);
    if (inertial_cal !== 1'b1) cal_bad++;
    checks++;
    if (cal_bad != 0) begin
      errors++;
      $display("FAIL cal_hold: %0d bad cycles want 0", cal_bad);
    end
    step();
    cal_done = 1'b0;
    @(negedge clk);
    checks++;
    if (link.send_resp !== 1'b1 || link.clr_cmd_rdy !== 1'b1 || link.resp !== 8'hA5 ||
        inertial_cal !== 1'b0 || motors_off !== 1'b0) begin
      errors++;
      $display("FAIL cal_ack: send=%b clr=%b resp=%h ical=%b moff=%b want 1 1 a5 0 0",
               link.send_resp, link.clr_cmd_rdy, link.resp, inertial_cal, motors_off);
    end
  endtask

  task automatic test_wdog();
    int early;
    early = 0;
    run_cmd(8'h05, 16'h0100);
`ifdef CMD_WDOG_EN
    // run_cmd ended in the first silent idle cycle; the 15th silent cycle trips
    for (int k = 2; k <= 15; k++) begin
      step();
      @(negedge clk);
      if (thrst !== 9'h100 || wdog_trip !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL wdog_early: %0d cycles tripped early want 0", early);
    end
    step();
    @(negedge clk);
    for (int k = 0; k < NUM_SP; k++) sp_m[k] = '0;
    thrst_m = '0;
    trip_m  = 1'b1;
    checks++;
    if (thrst !== '0 || sp !== '0 || wdog_trip !== 1'b1 || motors_off !== 1'b0) begin
      errors++;
      $display("FAIL wdog_trip: thrst=%h sp=%h trip=%b moff=%b want 0 0 1 0",
               thrst, sp, wdog_trip, motors_off);
    end
`else
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      if (thrst !== 9'h100 || wdog_trip !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL no_wdog: %0d cycles with trip or lost thrust want 0", early);
    end
`endif
    run_cmd(8'h08, 16'h0);
  endtask

  task automatic test_random();
    logic [7:0]        op;
    logic [DATA_W-1:0] dat;
    int                sel;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      dat = DATA_W'($urandom);
      case (sel)
        0, 1, 2: op = 8'h10 + 8'($urandom_range(0, NUM_SP - 1));
        3:       op = 8'h05;
        4:       op = 8'h07;
        5:       op = 8'h08;
        6: begin
          op = 8'($urandom_range(0, 255));
          if (legal(op)) op = 8'hFF;
        end
        default: op = 8'h01;
      endcase
      if (op == 8'h01) test_batt(int'($urandom_range(1, 6)), 8'($urandom));
      else             run_cmd(op, dat);
    end
  endtask

  task automatic test_rst_mid_ramp();
    int stray;
    present(8'h06, 16'h0);
    step();
    link.cmd_rdy = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sp, thrst, motors_off, wdog_trip, link.resp, link.send_resp, link.clr_cmd_rdy,
         strt_cnv, strt_cal, inertial_cal} !== {{(NUM_SP*SP_W+THRST_W){1'b0}}, 2'b10, 8'hA5, 5'b0})
      begin
        errors++;
        $display("FAIL rst_mid_ramp: sp=%h thrst=%h moff=%b trip=%b resp=%h",
                 sp, thrst, motors_off, wdog_trip, link.resp);
      end
    model_reset();
    step();
    step();
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      @(negedge clk);
      if (strt_cal !== 1'b0 || inertial_cal !== 1'b0 || motors_off !== 1'b1 || link.send_resp !== 1'b0)
        stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL post_rst_quiet: %0d cycles with activity want 0", stray);
    end
    run_cmd(8'h12, 16'hBEEF);
  endtask

  initial begin
    rst          = 1'b1;
    link.cmd     = 8'h00;
    link.data    = '0;
    link.cmd_rdy = 1'b0;
    batt         = 8'h00;
    cnv_cmplt    = 1'b0;
    cal_done     = 1'b0;
    model_reset();
    test_reset();
    test_set_sp();
    test_thrst_emer();
    test_batt(20, 8'h7C);
    test_nack();
    test_calibrate();
    test_wdog();
    test_random();
    test_rst_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cmd_cfg_mc.md
Name: cmd_cfg_mc

Overview:
- Multi-channel, parametrised command interpreter for the quad flight controller.
- Decodes 8-bit opcode plus DATA_W-bit payload commands from the UART/BLE wrapper.
- Holds NUM_SP signed setpoint channels and an unsigned thrust register, sequences battery reads and motor-ramp/inertial calibration, and returns an 8-bit response byte per command.
- New over the fixed three-axis unit: configurable channel count and widths, a NACK for illegal opcodes, and an optional link-loss watchdog that forces emergency land.

Parameters:
- NUM_SP, 3, number of signed setpoint channels (1..16)
- SP_W, 16, setpoint width in bits (SP_W <= DATA_W)
- THRST_W, 9, thrust width in bits (THRST_W <= DATA_W)
- DATA_W, 16, command payload width
- RAMP_W, 9, motor-ramp timer width (26 on the flight build)
- WDOG_W, 12, watchdog counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd  in  8  opcode
- data  in  DATA_W  payload
- cmd_rdy  in  1  command valid, level, held until clr_cmd_rdy
- batt  in  8  battery ADC result
- cnv_cmplt  in  1  ADC conversion done pulse
- cal_done  in  1  inertial calibration done pulse
- sp  out  NUM_SP*SP_W  setpoints, channel k at [k*SP_W +: SP_W], signed
- thrst  out  THRST_W  thrust
- resp  out  8  response byte
- send_resp  out  1  one-cycle response strobe
- clr_cmd_rdy  out  1  one-cycle command consume strobe
- strt_cnv  out  1  one-cycle ADC start
- strt_cal  out  1  one-cycle calibration start
- inertial_cal  out  1  high throughout calibration
- motors_off  out  1  motor disable
- wdog_trip  out  1  sticky link-loss flag

Behaviour:
- Opcodes:
  - 0x01 REQ_BATT
  - 0x05 SET_THRST
  - 0x06 CALIBRATE
  - 0x07 EMER_LAND
  - 0x08 MTRS_OFF
  - 0x10+k SET_SP channel k, for k < NUM_SP
  - All other opcodes are illegal.
- Reset values:
  - sp = 0, thrst = 0, motors_off = 1, wdog_trip = 0.
  - resp = 0xA5; all strobes and inertial_cal = 0; state IDLE.
- States: IDLE, BATT, ACK, NACK, RAMP, CAL.
- IDLE, cmd_rdy=1 in cycle N, decode:
  - SET_SP k: sp[k] <= data[SP_W-1:0]; go to ACK.
  - SET_THRST: thrst <= data[THRST_W-1:0]; go to ACK.
  - EMER_LAND: all sp and thrst <= 0; go to ACK.
  - MTRS_OFF: motors_off <= 1; go to ACK.
  - REQ_BATT: strt_cnv=1 in cycle N; go to BATT.
  - CALIBRATE: clr_cmd_rdy=1 in cycle N; motors_off <= 0; go to RAMP.
  - Illegal: go to NACK; no register changes.
- ACK: resp=0xA5, send_resp=1, clr_cmd_rdy=1 for one cycle; go to IDLE. For written commands, send_resp is asserted in cycle N+1.
- NACK: resp=0xEE, send_resp=1, clr_cmd_rdy=1 for one cycle; go to IDLE.
- BATT:
  - Waits for cnv_cmplt.
  - In that cycle: resp=batt, send_resp=1, clr_cmd_rdy=1; go to IDLE.
  - No timeout.
- RAMP:
  - Ramp timer is cleared in every state except RAMP and increments each RAMP cycle.
  - When the timer is all-ones: strt_cal=1 for that cycle; go to CAL. RAMP therefore lasts exactly 2^RAMP_W cycles.
  - motors_off is held 0 throughout.
- CAL:
  - inertial_cal=1 every cycle.
  - On cal_done: go to ACK, which produces a second clr_cmd_rdy. That is harmless and required.
- cmd_rdy is ignored in every state except IDLE.
- Priority: a zeroing event (EMER_LAND or watchdog trip) overrides any same-cycle setpoint or thrust write. MTRS_OFF overrides motor enable.
- resp = 0xA5 whenever it is not driven otherwise.
- Asserting rst in any state immediately returns all outputs to their reset values and the state to IDLE. No response is issued for an interrupted command.

Optional Feature:
- Macro: CMD_WDOG_EN.
- Defined:
  - A WDOG_W-bit counter increments each cycle while motors_off=0 and the state is IDLE with cmd_rdy=0.
  - It clears on any accepted command (IDLE with cmd_rdy=1) and while motors_off=1.
  - On reaching all-ones: all sp and thrst <= 0, wdog_trip <= 1, counter clears.
  - wdog_trip clears on the next accepted legal command.
  - motors_off is unchanged by a trip.
- Undefined: no counter; wdog_trip is tied 0.

Test Plan:
- Reset, then cmd=0x11, data=0x8001, cmd_rdy=1 → sp[1]=0x8001 the next cycle; send_resp and clr_cmd_rdy one cycle later with resp=0xA5; sp[0] and sp[2] remain 0.
- cmd=0x05, data=0xFFFF → thrst=0x1FF. Then cmd=0x07 → sp all 0, thrst=0, ACK 0xA5.
- cmd=0x01 with batt=0x7C and cnv_cmplt 20 cycles after strt_cnv → one send_resp with resp=0x7C in the cnv_cmplt cycle; strt_cnv is exactly one pulse.
- cmd=0x06 → clr_cmd_rdy the same cycle; motors_off=0; strt_cal exactly 512 cycles after entering RAMP; inertial_cal held until cal_done, then ACK 0xA5.
- cmd=0x13 (NUM_SP=3) and cmd=0x00 → resp=0xEE with send_resp; no register change. Asserting rst mid-RAMP → motors_off=1, state IDLE, no strt_cal.
- CMD_WDOG_EN with WDOG_W=4: motors on, thrst=0x100, idle 15 cycles → thrst=0, wdog_trip=1. The next legal command clears wdog_trip.
